ws2812_rx: RTL

- Single-wire NRZ pixel receiver: the decoding end of the LED-strip protocol our strip driver transmits on gpio_0.
- Samples the serial line, classifies each high pulse as a 0 or 1 bit, and assembles 24-bit GRB words. Emits each word as an RGB pixel strobe with its index in the frame, and reports frame end at the latch (reset) gap.
- Used for loopback self-test of the strip driver and as the input stage of a chained pixel-forwarding node.

---
 rtl/ws2812_rx_if.sv | 21 ++
 rtl/ws2812_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx_if.sv
// Pixel/frame result bundle of the WS2812 receiver.
// master: receiver drives strobes, pixel data and status; slave: consumer.
interface ws2812_rx_if;
    logic        pixel_valid;
    logic [23:0] pixel_color;
    logic [6:0]  pixel_index;
    logic        frame_done;
    logic [7:0]  pixel_count;
    logic        bit_error;
    logic        overflow;

    modport master (
        output pixel_valid, pixel_color, pixel_index,
        output frame_done, pixel_count, bit_error, overflow
    );

    modport slave (
        input pixel_valid, pixel_color, pixel_index,
        input frame_done, pixel_count, bit_error, overflow
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: decodes pulse widths into 24-bit GRB words and
// emits {R,G,B} pixel strobes plus frame-end/error status.
// Ports: clk, reset (sync, active-high), din (async line), pix (result bus).
module ws2812_rx #(
    parameter int BIT_THRESH   = 30,
    parameter int MIN_HIGH     = 8,
    parameter int MAX_HIGH     = 60,
    parameter int RESET_CYCLES = 2500,
    parameter int MAX_PIXELS   = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    ws2812_rx_if.master pix
);

    localparam logic [7:0]  THR   = 8'(BIT_THRESH);
    localparam logic [7:0]  MINH  = 8'(MIN_HIGH);
    localparam logic [7:0]  MAXH  = 8'(MAX_HIGH);
    localparam logic [15:0] RST_C = 16'(RESET_CYCLES);
    localparam logic [6:0]  MAXP  = 7'(MAX_PIXELS);

    typedef enum logic [1:0] {
        WAIT_LATCH,
        IDLE,
        HIGH,
        LOW
    } state_t;

    logic s1, s2, s3;
    logic lvl, rise, fall;

    state_t      state, state_n;
    logic [7:0]  high_cnt, high_n;
    logic [15:0] low_cnt, low_n;
    logic [4:0]  bit_cnt, bit_n;
    logic [6:0]  pix_idx, idx_n;
    logic [23:0] shreg, sh_n;

    // One-cycle event stage between the FSM and the output registers.
    logic       ev_pix, ev_pix_n;
    logic       ev_ovf, ev_ovf_n;
    logic       ev_clr, ev_clr_n;
    logic       ev_frame, ev_frame_n;
    logic       ev_err, ev_err_n;
    logic [6:0] ev_idx, ev_idx_n;
    logic [7:0] ev_cnt, ev_cnt_n;

    logic [7:0]  hi_inc;
    logic [15:0] lo_inc;

    // Edge flags are registered so lvl, rise and fall stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            lvl  <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign hi_inc = (high_cnt == 8'hFF) ? high_cnt : high_cnt + 8'd1;
    assign lo_inc = (low_cnt == 16'hFFFF) ? low_cnt : low_cnt + 16'd1;

    always_comb begin
        state_n    = state;
        high_n     = high_cnt;
        low_n      = low_cnt;
        bit_n      = bit_cnt;
        idx_n      = pix_idx;
        sh_n       = shreg;
        ev_pix_n   = 1'b0;
        ev_ovf_n   = 1'b0;
        ev_clr_n   = 1'b0;
        ev_frame_n = 1'b0;
        ev_err_n   = 1'b0;
        ev_idx_n   = ev_idx;
        ev_cnt_n   = ev_cnt;
        unique case (state)
            WAIT_LATCH: begin
                if (lvl) begin
                    low_n = '0;
                end else if (low_cnt >= RST_C) begin
                    state_n = IDLE;
                end else begin
                    low_n = lo_inc;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_n  = HIGH;
                    high_n   = 8'd1;
                    bit_n    = '0;
                    idx_n    = '0;
                    ev_clr_n = 1'b1;
                end
            end
            HIGH: begin
                if (high_cnt > MAXH) begin
                    ev_err_n = 1'b1;
                    low_n    = '0;
                    state_n  = WAIT_LATCH;
                end else if (fall) begin
                    if (high_cnt < MINH) begin
                        ev_err_n = 1'b1;
                        low_n    = '0;
                        state_n  = WAIT_LATCH;
                    end else begin
                        sh_n    = {shreg[22:0], high_cnt >= THR};
                        low_n   = 16'd1;
                        state_n = LOW;
                        if (bit_cnt == 5'd23) begin
                            bit_n = '0;
                            if (pix_idx < MAXP) begin
                                ev_pix_n = 1'b1;
                                ev_idx_n = pix_idx;
                            end else begin
                                ev_ovf_n = 1'b1;
                            end
                            if (pix_idx != 7'h7F) begin
                                idx_n = pix_idx + 7'd1;
                            end
                        end else begin
                            bit_n = bit_cnt + 5'd1;
                        end
                    end
                end else begin
                    high_n = hi_inc;
                end
            end
            LOW: begin
                // Frame end wins over a coincident rise.
                if (low_cnt >= RST_C) begin
                    ev_frame_n = 1'b1;
                    ev_err_n   = (bit_cnt != 5'd0);
                    ev_cnt_n   = (pix_idx < MAXP) ? {1'b0, pix_idx}
                                                  : 8'(MAX_PIXELS);
                    bit_n      = '0;
                    state_n    = IDLE;
                end else if (rise) begin
                    high_n  = 8'd1;
                    state_n = HIGH;
                end else begin
                    low_n = lo_inc;
                end
            end
            default: state_n = WAIT_LATCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WAIT_LATCH;
            high_cnt <= '0;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            pix_idx  <= '0;
            shreg    <= '0;
            ev_pix   <= 1'b0;
            ev_ovf   <= 1'b0;
            ev_clr   <= 1'b0;
            ev_frame <= 1'b0;
            ev_err   <= 1'b0;
            ev_idx   <= '0;
            ev_cnt   <= '0;
        end else begin
            state    <= state_n;
            high_cnt <= high_n;
            low_cnt  <= low_n;
            bit_cnt  <= bit_n;
            pix_idx  <= idx_n;
            shreg    <= sh_n;
            ev_pix   <= ev_pix_n;
            ev_ovf   <= ev_ovf_n;
            ev_clr   <= ev_clr_n;
            ev_frame <= ev_frame_n;
            ev_err   <= ev_err_n;
            ev_idx   <= ev_idx_n;
            ev_cnt   <= ev_cnt_n;
        end
    end

    // Received order is G,R,B; present as R,G,B.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix.pixel_valid <= 1'b0;
            pix.pixel_color <= '0;
            pix.pixel_index <= '0;
            pix.frame_done  <= 1'b0;
            pix.pixel_count <= '0;
            pix.bit_error   <= 1'b0;
            pix.overflow    <= 1'b0;
        end else begin
            pix.pixel_valid <= ev_pix;
            pix.frame_done  <= ev_frame;
            pix.bit_error   <= ev_err;
            if (ev_pix) begin
                pix.pixel_color <= {shreg[15:8], shreg[23:16], shreg[7:0]};
                pix.pixel_index <= ev_idx;
            end
            if (ev_frame) begin
                pix.pixel_count <= ev_cnt;
            end
            if (ev_clr) begin
                pix.overflow <= 1'b0;
            end else if (ev_ovf) begin
                pix.overflow <= 1'b1;
            end
        end
    end

endmodule
